// File: rtl/imem_responder.sv
// Instruction-memory responder: valid/ready fetch port with WAIT_STATES latency,
// flush abort and a word-write load port. Define IMEM_PREFETCH_EN for the sequential prefetch buffer.
module imem_responder #(
  parameter int WIDTH       = 32,
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [WIDTH-1:0]      req_addr,
  input  logic                  flush,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_instr,
  output logic [WIDTH-1:0]      rsp_addr,
  output logic                  rsp_fault,
  input  logic                  ld_we,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [WIDTH-1:0]      ld_data
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  function automatic logic is_fault(input logic [WIDTH-1:0] a);
    return (a[1:0] != 2'b00) || ((a >> (DEPTH_LOG2 + 2)) != '0);
  endfunction

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_addr;
  logic             r_armed;
  logic [WIDTH-1:0] r_rsp_instr, r_rsp_addr;
  logic             r_rsp_fault;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic             w_accept, w_rsp_load, w_rsp_from_pf;
  logic [WIDTH-1:0] w_rd_addr;
  logic             w_pf_hit_valid, w_pf_hit_busy;
  logic [3:0]       w_pf_cnt;
  logic [WIDTH-1:0] w_pf_data;

  // r_armed masks the edge on which reset is released, so a request there is ignored.
  assign req_ready = r_armed && !flush &&
                     (r_state == S_IDLE || (r_state == S_RESP && rsp_ready));
  assign w_accept  = req_valid && req_ready;
  assign w_rd_addr = w_accept ? req_addr : r_addr;
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_instr = r_rsp_instr;
  assign rsp_addr  = r_rsp_addr;
  assign rsp_fault = r_rsp_fault;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_rsp_load    = 1'b0;
    w_rsp_from_pf = 1'b0;
    if (flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE, S_RESP: begin
          if (r_state == S_RESP && rsp_ready) w_state_nxt = S_IDLE;
          if (w_accept) begin
            if (w_pf_hit_valid) begin
              w_state_nxt   = S_RESP;
              w_rsp_load    = 1'b1;
              w_rsp_from_pf = 1'b1;
            end else if (w_pf_hit_busy && w_pf_cnt != 4'd0) begin
              w_state_nxt = S_BUSY;
              w_cnt_nxt   = w_pf_cnt - 4'd1;
            end else if (w_pf_hit_busy || WAIT_STATES == 0) begin
              w_state_nxt = S_RESP;
              w_rsp_load  = 1'b1;
            end else begin
              w_state_nxt = S_BUSY;
              w_cnt_nxt   = WAIT_CNT;
            end
          end
        end
        S_BUSY: begin
          if (r_cnt == 4'd0) begin
            w_state_nxt = S_RESP;
            w_rsp_load  = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt - 4'd1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_armed     <= 1'b0;
      r_rsp_instr <= '0;
      r_rsp_addr  <= '0;
      r_rsp_fault <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values, which is also what gives read-before-write on r_mem.
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_armed <= 1'b1;
      if (w_accept) r_addr <= req_addr;
      if (w_rsp_load) begin
        r_rsp_addr  <= w_rd_addr;
        r_rsp_fault <= is_fault(w_rd_addr);
        if (is_fault(w_rd_addr))  r_rsp_instr <= '0;
        else if (w_rsp_from_pf)   r_rsp_instr <= w_pf_data;
        else                      r_rsp_instr <= r_mem[w_rd_addr[DEPTH_LOG2+1:2]];
      end
    end
  end

  // NOTE: the memory array has no reset; its contents come only from the load port.
  always_ff @(posedge clk) begin
    if (ld_we) r_mem[ld_addr] <= ld_data;
  end

`ifdef IMEM_PREFETCH_EN
  logic             r_pf_valid, r_pf_busy;
  logic [WIDTH-1:0] r_pf_addr, r_pf_data;
  logic [3:0]       r_pf_cnt;
  logic [WIDTH-1:0] w_pf_next;
  logic             w_pf_start, w_pf_kill;

  // Start only after a clean handshake that leaves the responder idle.
  assign w_pf_next  = r_rsp_addr + WIDTH'(4);
  assign w_pf_start = (r_state == S_RESP) && rsp_ready && !flush && !w_accept &&
                      !r_rsp_fault && !is_fault(w_pf_next);
  assign w_pf_kill  = flush || w_accept ||
                      (ld_we && (ld_addr == r_pf_addr[DEPTH_LOG2+1:2]));

  assign w_pf_hit_valid = r_pf_valid && (req_addr == r_pf_addr);
  assign w_pf_hit_busy  = r_pf_busy  && (req_addr == r_pf_addr);
  assign w_pf_cnt       = r_pf_cnt;
  assign w_pf_data      = r_pf_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pf_valid <= 1'b0;
      r_pf_busy  <= 1'b0;
      r_pf_addr  <= '0;
      r_pf_data  <= '0;
      r_pf_cnt   <= '0;
    end else if (w_pf_start) begin
      r_pf_valid <= 1'b0;
      r_pf_busy  <= 1'b1;
      r_pf_addr  <= w_pf_next;
      r_pf_cnt   <= WAIT_CNT;
    end else if (w_pf_kill) begin
      r_pf_valid <= 1'b0;
      r_pf_busy  <= 1'b0;
    end else if (r_pf_busy) begin
      if (r_pf_cnt == 4'd0) begin
        r_pf_busy  <= 1'b0;
        r_pf_valid <= 1'b1;
        r_pf_data  <= r_mem[r_pf_addr[DEPTH_LOG2+1:2]];
      end else begin
        r_pf_cnt <= r_pf_cnt - 4'd1;
      end
    end
  end
`else
  assign w_pf_hit_valid = 1'b0;
  assign w_pf_hit_busy  = 1'b0;
  assign w_pf_cnt       = 4'd0;
  assign w_pf_data      = '0;
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: directed scenarios then randomized traffic,
// checked cycle by cycle against a transaction-level reference model.
module tb_imem_responder;

  localparam int WIDTH = 32;
  localparam int DL    = 8;
  localparam int DEPTH = 1 << DL;
  localparam int W     = 2;
  // Negedge of the accept cycle to the first negedge showing rsp_valid.
  localparam int LAT   = (W == 0) ? 1 : W + 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [WIDTH-1:0] req_addr = '0;
  logic             flush = 1'b0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [WIDTH-1:0] rsp_instr, rsp_addr;
  logic             rsp_fault;
  logic             ld_we = 1'b0;
  logic [DL-1:0]    ld_addr = '0;
  logic [WIDTH-1:0] ld_data = '0;

  imem_responder #(.WIDTH(WIDTH), .DEPTH_LOG2(DL), .WAIT_STATES(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .flush(flush),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr),
    .rsp_addr(rsp_addr), .rsp_fault(rsp_fault),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] addr;
    int               due;
    logic [WIDTH-1:0] instr;
    logic             fault;
    bit               cap;
  } exp_t;

  exp_t             q[$];
  logic [WIDTH-1:0] m_mem [DEPTH];
  int               cyc = 0;
  bit               m_armed = 1'b0;
  int               n_checks = 0;
  int               n_fail = 0;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst) begin
    if (!rst) m_armed <= 1'b0;
    else      m_armed <= 1'b1;
  end

  // Monitor / scoreboard: everything expected is derived from the model state.
  initial begin
    exp_t e;
    bit   exp_valid, exp_ready;
    forever begin
      @(negedge clk);
      if (!rst) begin
        q.delete();
        check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("rst_req_ready", 32'(req_ready), 32'(0));
        check("rst_rsp_instr", rsp_instr, 32'(0));
        check("rst_rsp_addr",  rsp_addr,  32'(0));
        check("rst_rsp_fault", 32'(rsp_fault), 32'(0));
      end else begin
        exp_valid = (q.size() > 0) && (q[0].due <= cyc);
        exp_ready = m_armed && !flush && ((q.size() == 0) || (exp_valid && rsp_ready));
        check("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        if (exp_valid) begin
          check("rsp_instr", rsp_instr, q[0].instr);
          check("rsp_addr",  rsp_addr,  q[0].addr);
          check("rsp_fault", 32'(rsp_fault), 32'(q[0].fault));
        end
        if (flush) begin
          q.delete();
        end else begin
          if (exp_valid && rsp_ready) void'(q.pop_front());
          if (req_valid && exp_ready) begin
            e.addr  = req_addr;
            e.due   = cyc + LAT;
            e.instr = '0;
            e.fault = 1'b0;
            e.cap   = 1'b0;
            q.push_back(e);
          end
        end
        // Memory is sampled on the edge that enters RESP, before this cycle's load write.
        if (q.size() > 0 && !q[0].cap && q[0].due == cyc + 1) begin
          e       = q[0];
          e.fault = (e.addr[1:0] != 2'b00) || (e.addr >= WIDTH'(4 * DEPTH));
          e.instr = e.fault ? '0 : m_mem[e.addr[DL+1:2]];
          e.cap   = 1'b1;
          q[0]    = e;
        end
      end
      if (ld_we) m_mem[ld_addr] = ld_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [WIDTH-1:0] a);
    req_valid = 1'b1;
    req_addr  = a;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] last_addr;
    int               r;
    #1 rst = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();

    for (int i = 0; i < DEPTH; i++) begin
      ld_we   = 1'b1;
      ld_addr = DL'(i);
      ld_data = (i == 1) ? 32'h2008_0005 : $urandom;
      step();
    end
    ld_we = 1'b0;

    // Basic fetch of word 1.
    rsp_ready = 1'b1;
    request(32'h4);
    repeat (5) step();

    // Held response under backpressure, then back-to-back accept on the handshake.
    rsp_ready = 1'b0;
    request(32'h8);
    repeat (LAT + 4) step();
    rsp_ready = 1'b1;
    request(32'hC);
    repeat (5) step();

    // Misaligned and out-of-range addresses.
    request(32'h6);
    repeat (5) step();
    request(32'h400);
    repeat (5) step();

    // Flush one cycle after accept, then a normal fetch.
    request(32'h10);
    flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (2) step();
    request(32'h20);
    repeat (5) step();

    // Load write landing on the RESP-entry edge returns the old word.
    request(32'h24);
    repeat (LAT - 2) step();
    ld_we   = 1'b1;
    ld_addr = DL'(9);
    ld_data = 32'hCAFE_F00D;
    step();
    ld_we = 1'b0;
    repeat (4) step();
    request(32'h24);
    repeat (5) step();

    // Reset asserted mid-BUSY; request held across the release edge.
    request(32'h4);
    step();
    #2 rst = 1'b0;
    repeat (2) step();
    req_valid = 1'b1;
    req_addr  = 32'h4;
    @(negedge clk);
    #2 rst = 1'b1;
    step();
    req_valid = 1'b0;
    repeat (6) step();

    // Randomized traffic with occasional flushes and load writes.
    last_addr = 32'h0;
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 9);
      if (r < 6)       req_addr = {22'd0, 8'($urandom_range(0, DEPTH - 1)), 2'b00};
      else if (r == 6) req_addr = {22'd0, 8'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(1, 3))};
      else if (r == 7) req_addr = $urandom | 32'h400;
      else             req_addr = last_addr + 32'h4;
      last_addr = req_addr;
      req_valid = ($urandom_range(0, 9) < 6);
      rsp_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 19) == 0);
      ld_we     = ($urandom_range(0, 19) == 0);
      ld_addr   = DL'($urandom_range(0, DEPTH - 1));
      ld_data   = $urandom;
      step();
    end
    req_valid = 1'b0;
    flush     = 1'b0;
    ld_we     = 1'b0;
    rsp_ready = 1'b1;
    repeat (LAT + 6) step();
    check("drain_empty", 32'(q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
